column_issuer: RTL and testbench

COLUMN_ISSUER -- requirements
Module: column_issuer

---
 rtl/column_issuer.sv | 141 ++++++++++++++
 tb/tb_column_issuer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/column_issuer.sv
// Column issuer: streams source-bank columns to a normalizer one at a time
// and collects the normalized columns into a result bank.
module column_issuer #(
  parameter int MAT_SIZE = 5,
  parameter int DATWIDTH = 64,
  parameter int MAX_WAIT = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   ldVld,
  input  logic [$clog2(MAT_SIZE):0]              ldCol,
  input  logic [MAT_SIZE-1:0][DATWIDTH-1:0]      ldColumn,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   timeoutErr,
  output logic                                   inputReady,
  output logic [$clog2(MAT_SIZE):0]              opCnt,
  output logic [MAT_SIZE-1:0][DATWIDTH-1:0]      opColumn,
  input  logic                                   outVld,
  input  logic [MAT_SIZE-1:0][DATWIDTH-1:0]      opColumnNorm,
  input  logic [$clog2(MAT_SIZE):0]              rdCol,
  output logic [MAT_SIZE-1:0][DATWIDTH-1:0]      rdColumn
);

  localparam int CW = $clog2(MAT_SIZE) + 1;
  localparam int AW = $clog2(MAT_SIZE);
  localparam int WW = $clog2(MAX_WAIT);
  localparam logic [CW-1:0] NCOL = CW'(MAT_SIZE);
  localparam logic [CW-1:0] LAST = CW'(MAT_SIZE - 1);
  localparam logic [WW-1:0] WLIM = WW'(MAX_WAIT - 2);

  typedef logic [MAT_SIZE-1:0][DATWIDTH-1:0] col_t;
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t        state_q, state_d;
  col_t          src_q [MAT_SIZE];
  col_t          res_q [MAT_SIZE];
  col_t          rd_q;
  logic [CW-1:0] cnt_q;
  logic [WW-1:0] wcnt_q;
  logic          tmo_q;
  logic          cap, tmo, ld_ok, rd_ok;

  assign cap   = (state_q == WAIT) && outVld;
  // Counter reaching MAX_WAIT-1 on this edge means the wait expired
  assign tmo   = (state_q == WAIT) && !outVld && (wcnt_q == WLIM);
  assign ld_ok = (state_q == IDLE) && ldVld && (ldCol < NCOL);
  assign rd_ok = rdCol < NCOL;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (cap) begin
          state_d = (cnt_q == LAST) ? DONE : ISSUE;
        end else if (tmo) begin
          state_d = IDLE;
        end
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b1;
    done       = 1'b0;
    inputReady = 1'b0;
    opColumn   = src_q[cnt_q[AW-1:0]];
    unique case (state_q)
      IDLE: begin
        busy     = 1'b0;
        opColumn = '0;
      end
      ISSUE:   inputReady = 1'b1;
      WAIT:    ;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign opCnt      = cnt_q;
  assign timeoutErr = tmo_q;
  assign rdColumn   = rd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAT_SIZE; i++) begin
        src_q[i] <= '0;
        res_q[i] <= '0;
      end
      rd_q   <= '0;
      cnt_q  <= '0;
      wcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      // Nonblocking read returns pre-capture data on a same-column hit
      rd_q <= rd_ok ? res_q[rdCol[AW-1:0]] : '0;
      if (ld_ok) src_q[ldCol[AW-1:0]] <= ldColumn;
      if (cap)   res_q[cnt_q[AW-1:0]] <= opColumnNorm;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
          end
        end
        ISSUE: wcnt_q <= '0;
        WAIT: begin
          if (cap) begin
            if (cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
          end else if (tmo) begin
            tmo_q <= 1'b1;
            cnt_q <= '0;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        DONE:    cnt_q <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_column_issuer.sv
// Directed + randomized bench for column_issuer against a
// column-level reference model of the banks and pass sequencing.
module tb_column_issuer;

  localparam int MS = 5;
  localparam int DW = 64;
  localparam int MW = 64;
  localparam int CW = $clog2(MS) + 1;
  localparam int BW = MS * DW;

  typedef logic [MS-1:0][DW-1:0] col_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ldVld = 1'b0;
  logic          start = 1'b0;
  logic          outVld = 1'b0;
  logic [CW-1:0] ldCol = '0;
  logic [CW-1:0] rdCol = '0;
  logic [CW-1:0] opCnt;
  col_t          ldColumn = '0;
  col_t          opColumnNorm = '0;
  col_t          opColumn;
  col_t          rdColumn;
  logic          busy, done, timeoutErr, inputReady;

  col_t src_m [MS];
  col_t res_m [MS];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  column_issuer #(
    .MAT_SIZE(MS),
    .DATWIDTH(DW),
    .MAX_WAIT(MW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ldVld       (ldVld),
    .ldCol       (ldCol),
    .ldColumn    (ldColumn),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .timeoutErr  (timeoutErr),
    .inputReady  (inputReady),
    .opCnt       (opCnt),
    .opColumn    (opColumn),
    .outVld      (outVld),
    .opColumnNorm(opColumnNorm),
    .rdCol       (rdCol),
    .rdColumn    (rdColumn)
  );

  task automatic chk(input string tag, input logic [BW-1:0] obs,
                     input logic [BW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic col_t rd_model(input logic [CW-1:0] idx);
    int i;
    i = int'(idx);
    if (i >= MS) return '0;
    return res_m[i];
  endfunction

  function automatic col_t plus1(input col_t c);
    col_t o;
    for (int r = 0; r < MS; r++) o[r] = c[r] + 64'd1;
    return o;
  endfunction

  function automatic col_t rnd_col();
    col_t o;
    for (int r = 0; r < MS; r++) o[r] = {$urandom, $urandom};
    return o;
  endfunction

  // One clock; the read port is checked against the bank as it stood
  task automatic step();
    col_t exp_rd;
    exp_rd = reset ? rd_model(rdCol) : '0;
    @(posedge clk);
    #1;
    cyc++;
    chk("rdColumn", rdColumn, exp_rd);
  endtask

  task automatic load(input int c, input col_t d);
    ldVld    = 1'b1;
    ldCol    = CW'(c);
    ldColumn = d;
    step();
    ldVld = 1'b0;
    if (c < MS) src_m[c] = d;
  endtask

  task automatic read_all();
    for (int k = 0; k < 8; k++) begin
      rdCol = CW'(k);
      step();
    end
    step();
  endtask

  task automatic run_pass(input int lat, input bit rnd_norm,
                          input bit stray, input bit poke,
                          input bit co_load, input int abort_k);
    col_t nrm, cl;
    int   last;
    last  = 0;
    start = 1'b1;
    cl    = rnd_col();
    if (co_load) begin
      ldVld    = 1'b1;
      ldCol    = CW'(MS - 1);
      ldColumn = cl;
    end
    step();
    start = 1'b0;
    ldVld = 1'b0;
    if (co_load) src_m[MS-1] = cl;
    chk("timeoutErr_clr", timeoutErr, 0);
    for (int k = 0; k < MS; k++) begin
      chk("inputReady", inputReady, 1);
      chk("opCnt", opCnt, k);
      chk("opColumn", opColumn, src_m[k]);
      chk("busy", busy, 1);
      if (k > 0) chk("spacing", cyc - last, lat + 1);
      last = cyc;
      if (stray) begin
        outVld       = 1'b1;
        opColumnNorm = rnd_col();
      end
      step();
      outVld = 1'b0;
      chk("inputReady_low", inputReady, 0);
      chk("opCnt_hold", opCnt, k);
      if (k == abort_k) begin
        step();
        step();
        #1 reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ir", inputReady, 0);
        chk("abort_opCnt", opCnt, 0);
        chk("abort_opColumn", opColumn, 0);
        chk("abort_tmo", timeoutErr, 0);
        chk("abort_rd", rdColumn, 0);
        for (int c = 0; c < MS; c++) begin
          src_m[c] = '0;
          res_m[c] = '0;
        end
        step();
        chk("abort_nodone", done, 0);
        reset = 1'b1;
        rdCol = '0;
        step();
        step();
        chk("abort_idle", busy, 0);
        chk("abort_nodone2", done, 0);
        return;
      end
      for (int j = 1; j < lat; j++) begin
        if (poke && j == 1) begin
          start    = 1'b1;
          ldVld    = 1'b1;
          ldCol    = CW'(7);
          ldColumn = rnd_col();
        end
        if (poke && j == 2) begin
          ldVld    = 1'b1;
          ldCol    = CW'(1);
          ldColumn = rnd_col();
        end
        step();
        start = 1'b0;
        ldVld = 1'b0;
      end
      chk("opColumn_hold", opColumn, src_m[k]);
      nrm          = rnd_norm ? rnd_col() : plus1(src_m[k]);
      outVld       = 1'b1;
      opColumnNorm = nrm;
      step();
      outVld   = 1'b0;
      res_m[k] = nrm;
    end
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    step();
    chk("done_low", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_opCnt", opCnt, 0);
    chk("idle_opColumn", opColumn, 0);
  endtask

  initial begin
    int   n;
    bit   saw_done;
    col_t d;
    for (int c = 0; c < MS; c++) begin
      src_m[c] = '0;
      res_m[c] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tmo", timeoutErr, 0);
    chk("rst_ir", inputReady, 0);
    chk("rst_opCnt", opCnt, 0);
    chk("rst_opColumn", opColumn, 0);
    chk("rst_rd", rdColumn, 0);
    reset = 1'b1;
    step();

    for (int c = 0; c < MS; c++) begin
      for (int r = 0; r < MS; r++) d[r] = 64'(c * 16 + r);
      load(c, d);
    end
    load(7, rnd_col());
    run_pass(38, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    read_all();

    outVld       = 1'b1;
    opColumnNorm = rnd_col();
    step();
    step();
    outVld = 1'b0;
    chk("stray_idle_opCnt", opCnt, 0);
    read_all();

    rdCol = CW'(3);
    run_pass(int'($urandom_range(1, 12)), 1'b1, 1'b1, 1'b0, 1'b0, -1);
    run_pass(5, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    read_all();

    start = 1'b1;
    step();
    start = 1'b0;
    chk("tmo_ir", inputReady, 1);
    n        = 0;
    saw_done = 1'b0;
    while (busy && n < 200) begin
      step();
      n++;
      if (done) saw_done = 1'b1;
    end
    chk("tmo_cycles", n, MW);
    chk("tmo_flag", timeoutErr, 1);
    chk("tmo_nodone", saw_done, 0);
    chk("tmo_opCnt", opCnt, 0);
    chk("tmo_opColumn", opColumn, 0);
    read_all();
    run_pass(3, 1'b1, 1'b0, 1'b0, 1'b0, -1);

    run_pass(10, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    read_all();

    for (int c = 0; c < MS; c++) load(c, rnd_col());
    run_pass(int'($urandom_range(1, 8)), 1'b1, 1'b0, 1'b0, 1'b0, -1);
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
